synth_frame_rx: RTL and testbench
=================================

// Module: synth_frame_rx
// PURPOSE
//  FPGA-side receiver of the MCU->FPGA control protocol. Deserialises an SPI (mode 0, MSB first) byte
//  stream into a shadow synth_t. Checks sync, length and checksum, then commits the shadow atomically
//  to the synth_t output consumed by the wave generators, reverb and volume stages.
//  Bad or partial frames never reach the output.
// PARAMETERS
//  N_OSC      `N_OSCILLATORS  oscillator count; must match synth_t in protocol_pkg
//  ENV_LEN    `ENVELOPE_LEN   envelope stages per oscillator
//  SYNC_BYTE  8'hA5           first byte of every frame
// PORTS
//  clk        in   1    system clock; sole clock domain
//  rst        in   1    synchronous, active-high reset
//  spi_sclk   in   1    SPI clock from MCU, asynchronous; 2-FF synchronised inside
//  spi_cs_n   in   1    SPI chip select, active low, asynchronous; 2-FF synchronised
//  spi_mosi   in   1    SPI data, asynchronous; 2-FF synchronised
//  synth      out  synth_t  committed parameter set
//  frame_ok   out  1    1-cycle pulse on the cycle synth updates
//  frame_err  out  1    1-cycle pulse when a frame is discarded
// BEHAVIOUR
//  Reset: synth = reset_synth_t() values (all 0, every shape = SIN). frame_ok = 0, frame_err = 0.
//    FSM goes to IDLE. Shadow register and byte counter are cleared.
//    Reset mid-frame discards that frame silently: no frame_err pulse.
//  Bit layer:
//    - Sample mosi on the synchronised sclk rising edge while cs_n = 0.
//    - 8 bits form a byte; byte_valid pulses for 1 cycle.
//    - cs_n rising clears the bit count.
//    - Requires f_clk >= 8 * f_sclk.
//  Frame layout, in bytes, in synth_t declaration order:
//    SYNC, then wave_gens[0..N_OSC-1], then reverb, then volume, then CHK.
//    Per wave_gen: envelopes[0..ENV_LEN-1] as {rate, duration}, then freq, then shape.
//    Each 32-bit field is 4 bytes, big-endian. shape is 1 byte; bits[1:0] used, bits[7:2] ignored.
//    CHK = XOR of all payload bytes (SYNC excluded).
//    PAYLOAD_BYTES = N_OSC*(ENV_LEN*8+5)+8.
//  FSM states: IDLE, PAYLOAD, CHECK, WAIT_CS, DROP.
//    IDLE    -> PAYLOAD on byte == SYNC_BYTE; any other byte -> DROP with frame_err.
//    PAYLOAD -> writes each byte into the shadow at byte_cnt and XORs it into chk.
//               -> CHECK after byte PAYLOAD_BYTES-1.
//    CHECK   -> next byte compared to chk: match -> WAIT_CS; mismatch -> DROP with frame_err.
//    WAIT_CS -> cs_n rising: commit shadow to synth, pulse frame_ok, -> IDLE.
//               Any extra byte before cs_n rises -> DROP with frame_err.
//    DROP    -> ignores bytes; -> IDLE on cs_n rising.
//    cs_n rising in PAYLOAD or CHECK -> frame_err, shadow discarded, -> IDLE.
//  Latency: frame_ok and the new synth value appear together, 1 clk after synchronised cs_n rises.
//    synth holds its value otherwise.
//  Simultaneous last byte_valid and cs_n rising: the byte is processed first, then the cs_n rule.
//  byte_cnt width = $clog2(PAYLOAD_BYTES+1). It never wraps; the FSM bounds it.
// STRUCTURE
//  protocol_pkg: add SYNC_BYTE, function frame_bytes(n_osc, env_len), and typedef rx_state_t.
//  Sub-module spi_byte_rx: synchronisers, sclk/cs_n edge detection, shift register.
//    Outputs byte_valid, byte_data, cs_rise, cs_active.
//  Shadow is a flat byte array indexed by byte_cnt. It is mapped to synth_t by a combinational unpack
//    function in protocol_pkg that pads shape to 2 bits.
// TESTING
//  Config for all tests: N_OSC=2, ENV_LEN=2, so 50 payload bytes and 52 bytes per frame.
//  1. Reset: hold rst 3 clk -> synth all 0, shapes = SIN (2'd2), no pulses.
//  2. Good frame: A5, payload with wg[1].freq=32'h0001_B4E0, volume=32'h0000_8000, shape[0]=8'h01,
//     correct CHK, cs_n high -> single frame_ok; fields match; others 0.
//  3. Same frame with CHK^8'h01 -> frame_err once; synth unchanged; no frame_ok.
//  4. Truncated: cs_n high after 30 bytes -> frame_err; synth unchanged.
//     Next good frame commits normally.
//  5. First byte 8'h5A, then a full frame under the same cs_n -> frame_err; nothing committed
//     until a fresh cs_n cycle.
//  6. rst asserted at byte 20, then a good frame -> no frame_err; synth = the new frame.
//     Two back-to-back frames -> two frame_ok; final synth = frame 2.

Source files
------------

// File: rtl/synth_frame_rx_pkg.sv
// Shared types for the MCU->FPGA control protocol receiver:
// the synth parameter set, frame sizing and the shadow unpacker.
package synth_frame_rx_pkg;

    localparam int N_OSC   = 2;
    localparam int ENV_LEN = 2;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        SHAPE_SQR = 2'd0,
        SHAPE_SAW = 2'd1,
        SHAPE_SIN = 2'd2,
        SHAPE_TRI = 2'd3
    } shape_t;

    typedef struct packed {
        logic [31:0] rate;
        logic [31:0] duration;
    } env_t;

    typedef struct packed {
        env_t [ENV_LEN-1:0] envelopes;
        logic [31:0]        freq;
        shape_t             shape;
    } wave_gen_t;

    typedef struct packed {
        wave_gen_t [N_OSC-1:0] wave_gens;
        logic [31:0]           reverb;
        logic [31:0]           volume;
    } synth_t;

    // Whole frame on the wire: SYNC + payload + CHK.
    function automatic int frame_bytes(input int n_osc, input int env_len);
        return n_osc * (env_len * 8 + 5) + 10;
    endfunction

    localparam int PAYLOAD_BYTES = frame_bytes(N_OSC, ENV_LEN) - 2;
    localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);

    typedef logic [PAYLOAD_BYTES-1:0][7:0] shadow_t;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        WAIT_CS,
        DROP
    } rx_state_t;

    function automatic synth_t reset_synth();
        synth_t s;
        s = '0;
        for (int o = 0; o < N_OSC; o++) begin
            s.wave_gens[o].shape = SHAPE_SIN;
        end
        return s;
    endfunction

    function automatic logic [31:0] be32(input shadow_t f, input int p);
        return {f[p], f[p+1], f[p+2], f[p+3]};
    endfunction

    function automatic synth_t unpack_synth(input shadow_t f);
        synth_t s;
        int     p;
        s = '0;
        p = 0;
        for (int o = 0; o < N_OSC; o++) begin
            for (int e = 0; e < ENV_LEN; e++) begin
                s.wave_gens[o].envelopes[e].rate     = be32(f, p);
                s.wave_gens[o].envelopes[e].duration = be32(f, p + 4);
                p = p + 8;
            end
            s.wave_gens[o].freq  = be32(f, p);
            s.wave_gens[o].shape = shape_t'(f[p+4][1:0]);
            p = p + 5;
        end
        s.reverb = be32(f, p);
        s.volume = be32(f, p + 4);
        return s;
    endfunction

endpackage

// File: rtl/synth_frame_rx_spi_byte_rx.sv
// SPI mode-0 byte deserialiser: synchronises the async SPI pins,
// detects sclk/cs_n edges and assembles MSB-first bytes.
module synth_frame_rx_spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       cs_rise_o,
    output logic       cs_active_o
);

    logic [1:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;
    logic       cs_prev_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       cs_rise_q;

    logic sclk_rise;
    logic cs_rise;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= 2'b00;
            cs_sync_q    <= 2'b11;
            mosi_sync_q  <= 2'b00;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            cs_rise_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], sclk_i};
            cs_sync_q    <= {cs_sync_q[0], cs_n_i};
            mosi_sync_q  <= {mosi_sync_q[0], mosi_i};
            sclk_prev_q  <= sclk_sync_q[1];
            cs_prev_q    <= cs_sync_q[1];
            cs_rise_q    <= cs_rise;
            byte_valid_q <= 1'b0;
            if (cs_rise) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && !cs_sync_q[1]) begin
                shift_q   <= {shift_q[5:0], mosi_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q, mosi_sync_q[1]};
                end
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign cs_rise_o    = cs_rise_q;
    // Aligned with cs_rise_o: drops on the same cycle the rise is flagged.
    assign cs_active_o  = ~cs_prev_q;

endmodule

// File: rtl/synth_frame_rx.sv
// Frame receiver: validates sync, length and checksum of each SPI frame
// and commits the shadow parameter set atomically on cs_n release.
module synth_frame_rx
    import synth_frame_rx_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   spi_sclk,
    input  logic   spi_cs_n,
    input  logic   spi_mosi,
    output synth_t synth,
    output logic   frame_ok,
    output logic   frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cs_rise;
    logic       cs_active;

    rx_state_t        state_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [7:0]       chk_q;
    shadow_t          shadow_q;
    synth_t           synth_q;
    logic             ok_q;
    logic             err_q;

    synth_frame_rx_spi_byte_rx u_spi (
        .clk          (clk),
        .rst          (rst),
        .sclk_i       (spi_sclk),
        .cs_n_i       (spi_cs_n),
        .mosi_i       (spi_mosi),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .cs_rise_o    (cs_rise),
        .cs_active_o  (cs_active)
    );

    // A byte arriving with cs_rise is applied first, then the cs_n rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            chk_q      <= '0;
            shadow_q   <= '0;
            synth_q    <= reset_synth();
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (byte_valid) begin
                        if (byte_data == SYNC_BYTE) begin
                            byte_cnt_q <= '0;
                            chk_q      <= '0;
                            err_q      <= cs_rise;
                            state_q    <= cs_rise ? IDLE : PAYLOAD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= cs_rise ? IDLE : DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_valid) begin
                        shadow_q[byte_cnt_q] <= byte_data;
                        chk_q      <= chk_q ^ byte_data;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q == LAST_CNT) begin
                            state_q <= CHECK;
                        end
                    end
                    if (cs_rise) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                CHECK: begin
                    if (byte_valid && byte_data == chk_q) begin
                        if (cs_rise) begin
                            synth_q <= unpack_synth(shadow_q);
                            ok_q    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT_CS;
                        end
                    end else if (byte_valid) begin
                        err_q   <= 1'b1;
                        state_q <= cs_rise ? IDLE : DROP;
                    end else if (cs_rise) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WAIT_CS: begin
                    if (byte_valid) begin
                        err_q   <= 1'b1;
                        state_q <= cs_rise ? IDLE : DROP;
                    end else if (cs_rise) begin
                        synth_q <= unpack_synth(shadow_q);
                        ok_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (!cs_active) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign synth     = synth_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_synth_frame_rx.sv
// Directed bench for synth_frame_rx: frames are built from intended
// parameter sets and the outcome of each SPI transaction is predicted.
module tb_synth_frame_rx;
    import synth_frame_rx_pkg::*;

    localparam int FRM = 52;

    logic   clk  = 1'b0;
    logic   rst  = 1'b1;
    logic   sclk = 1'b0;
    logic   cs_n = 1'b1;
    logic   mosi = 1'b0;
    synth_t synth;
    logic   frame_ok;
    logic   frame_err;

    always #5 clk = ~clk;

    synth_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (sclk),
        .spi_cs_n  (cs_n),
        .spi_mosi  (mosi),
        .synth     (synth),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    int         pend_ok  = 0;
    int         pend_err = 0;
    synth_t     pend_synth;
    synth_t     cur_synth;
    synth_t     rst_val;
    synth_t     f1, f2, f3;
    logic [7:0] frm[$];
    logic [7:0] q[$];
    logic [7:0] fchk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_synth(input string name, input synth_t act,
                               input synth_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // One clock: sample outputs on the falling edge and compare to the model.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            cur_synth = rst_val;
            pend_ok   = 0;
            pend_err  = 0;
        end else begin
            if (frame_ok) begin
                check("ok_pulse_expected", 32'(pend_ok > 0), 32'd1);
                check_synth("synth_on_ok", synth, pend_synth);
                cur_synth = pend_synth;
                pend_ok--;
            end else begin
                check_synth("synth_hold", synth, cur_synth);
            end
            if (frame_err) begin
                check("err_pulse_expected", 32'(pend_err > 0), 32'd1);
                pend_err--;
            end
        end
    endtask

    // Frame outcome from the protocol rules: 0 none, 1 commit, 2 discard.
    function automatic int outcome(input logic [7:0] b[$]);
        logic [7:0] x;
        if (b.size() == 0) return 0;
        if (b[0] != 8'hA5) return 2;
        if (b.size() != FRM) return 2;
        x = 8'h00;
        for (int i = 1; i < FRM - 1; i++) x = x ^ b[i];
        return (x == b[FRM-1]) ? 1 : 2;
    endfunction

    task automatic put8(input logic [7:0] b);
        frm.push_back(b);
        fchk = fchk ^ b;
    endtask

    task automatic put32(input logic [31:0] v);
        for (int k = 3; k >= 0; k--) put8(v[k*8 +: 8]);
    endtask

    task automatic mk_frame(input synth_t s, input logic [5:0] shi);
        frm.delete();
        frm.push_back(8'hA5);
        fchk = 8'h00;
        for (int o = 0; o < 2; o++) begin
            for (int e = 0; e < 2; e++) begin
                put32(s.wave_gens[o].envelopes[e].rate);
                put32(s.wave_gens[o].envelopes[e].duration);
            end
            put32(s.wave_gens[o].freq);
            put8({shi, s.wave_gens[o].shape});
        end
        put32(s.reverb);
        put32(s.volume);
        frm.push_back(fchk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (4) tick();
            sclk = 1'b1;
            repeat (4) tick();
            sclk = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] b[$], input synth_t src);
        int r;
        r = outcome(b);
        if (r == 1) begin
            pend_ok++;
            pend_synth = src;
        end else if (r == 2) begin
            pend_err++;
        end
        cs_n = 1'b0;
        repeat (4) tick();
        foreach (b[i]) send_byte(b[i]);
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (16) tick();
        check("ok_outstanding", 32'(pend_ok), 32'd0);
        check("err_outstanding", 32'(pend_err), 32'd0);
    endtask

    initial begin
        rst_val = '0;
        for (int o = 0; o < 2; o++) rst_val.wave_gens[o].shape = SHAPE_SIN;
        cur_synth = rst_val;

        f1 = '0;
        f1.wave_gens[1].freq  = 32'h0001_B4E0;
        f1.volume             = 32'h0000_8000;
        f1.wave_gens[0].shape = SHAPE_SAW;

        f2 = '0;
        f2.wave_gens[0].envelopes[1].rate     = 32'h1234_5678;
        f2.wave_gens[1].envelopes[0].duration = 32'hDEAD_BEEF;
        f2.reverb             = 32'h0000_0F0F;
        f2.wave_gens[0].shape = SHAPE_TRI;
        f2.wave_gens[1].shape = SHAPE_SIN;

        f3 = '0;
        f3.wave_gens[0].freq                  = 32'hCAFE_0001;
        f3.wave_gens[1].envelopes[1].rate     = 32'h0000_00FF;
        f3.volume             = 32'hFFFF_FFFF;
        f3.wave_gens[0].shape = SHAPE_SAW;
        f3.wave_gens[1].shape = SHAPE_TRI;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_shape0", 32'(synth.wave_gens[0].shape), 32'd2);
        check("rst_shape1", 32'(synth.wave_gens[1].shape), 32'd2);
        check("rst_volume", synth.volume, 32'd0);
        check("rst_freq1", synth.wave_gens[1].freq, 32'd0);
        check("rst_ok", 32'(frame_ok), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);

        // Good frame
        mk_frame(f1, 6'h00);
        check("f1_len", 32'(frm.size()), 32'd52);
        check("f1_chk", 32'(fchk), 32'h0000_00D4);
        txn(frm, f1);
        check("t2_freq1", synth.wave_gens[1].freq, 32'h0001_B4E0);
        check("t2_volume", synth.volume, 32'h0000_8000);
        check("t2_shape0", 32'(synth.wave_gens[0].shape), 32'd1);
        check("t2_shape1", 32'(synth.wave_gens[1].shape), 32'd0);
        check("t2_reverb", synth.reverb, 32'd0);

        // Bad checksum
        q = frm;
        q[FRM-1] = q[FRM-1] ^ 8'h01;
        txn(q, f1);
        check("t3_volume_kept", synth.volume, 32'h0000_8000);

        // Truncated, then a good frame with junk in shape[7:2]
        mk_frame(f2, 6'h3F);
        q = frm[0:29];
        txn(q, f2);
        check("t4_trunc_kept", synth.wave_gens[1].freq, 32'h0001_B4E0);
        txn(frm, f2);
        check("t4_shape_hi_ignored", 32'(synth.wave_gens[0].shape), 32'd3);
        check("t4_env_rate", synth.wave_gens[0].envelopes[1].rate, 32'h1234_5678);
        check("t4_env_dur", synth.wave_gens[1].envelopes[0].duration, 32'hDEAD_BEEF);

        // Wrong first byte, full frame under the same cs_n
        mk_frame(f3, 6'h00);
        q = frm;
        q.push_front(8'h5A);
        txn(q, f3);
        check("t5_no_commit", synth.reverb, 32'h0000_0F0F);
        txn(frm, f3);
        check("t5_fresh_freq0", synth.wave_gens[0].freq, 32'hCAFE_0001);

        // Extra byte after CHK
        mk_frame(f1, 6'h00);
        q = frm;
        q.push_back(8'h00);
        txn(q, f1);
        check("extra_byte_kept", synth.volume, 32'hFFFF_FFFF);

        // Reset mid-frame: silent discard
        cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) send_byte(frm[i]);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        cs_n = 1'b1;
        repeat (16) tick();
        check("t6_rst_volume", synth.volume, 32'd0);
        check("t6_rst_shape0", 32'(synth.wave_gens[0].shape), 32'd2);
        txn(frm, f1);
        check("t6_new_freq1", synth.wave_gens[1].freq, 32'h0001_B4E0);

        // Back-to-back frames
        mk_frame(f2, 6'h00);
        txn(frm, f2);
        mk_frame(f3, 6'h15);
        txn(frm, f3);
        check("b2b_volume", synth.volume, 32'hFFFF_FFFF);
        check("b2b_shape1", 32'(synth.wave_gens[1].shape), 32'd3);
        check("b2b_rate", synth.wave_gens[1].envelopes[1].rate, 32'h0000_00FF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
